// File: rtl/display_page_scanner.sv
// display_page_scanner: picks one of NUM_PAGES left/right probe word pairs for the 7-seg banks (manual, auto-scan, freeze)
module display_page_scanner #(
  parameter int NUM_PAGES = 8,
  parameter int WORD_W = 16,
  parameter int DWELL = 50000,
  localparam int SEL_W = $clog2(NUM_PAGES)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_PAGES*2*WORD_W-1:0] page_data,
  input  logic [SEL_W-1:0]              selector_in,
  input  logic                          auto_mode,
  input  logic                          step,
  input  logic                          freeze,
  output logic [WORD_W-1:0]             l_digits,
  output logic [WORD_W-1:0]             r_digits,
  output logic [NUM_PAGES-1:0]          selector_out,
  output logic [SEL_W-1:0]              page_index,
  output logic                          frozen,
  output logic                          update_pulse
);
  localparam int CNT_W = $clog2(DWELL);
  typedef enum logic [1:0] {MANUAL, AUTO, FREEZE} state_t;
  state_t r_state, w_next;
  logic [SEL_W-1:0] r_page, w_page_inc;
  logic [CNT_W-1:0] r_cnt;
  logic r_oor, r_upd, w_adv, w_in_range;
  logic [WORD_W-1:0] r_l, r_r;
  logic [NUM_PAGES-1:0] r_sel, w_onehot;
  logic [WORD_W-1:0] w_l [NUM_PAGES];
  logic [WORD_W-1:0] w_r [NUM_PAGES];
  for (genvar g = 0; g < NUM_PAGES; g++) begin : g_page
    assign w_l[g] = page_data[(2*g+1)*WORD_W +: WORD_W];
    assign w_r[g] = page_data[2*g*WORD_W +: WORD_W];
  end
  assign w_next = freeze ? FREEZE : auto_mode ? AUTO : MANUAL;
  assign w_adv = step || r_cnt == CNT_W'(DWELL - 1);
  assign w_page_inc = r_page == SEL_W'(NUM_PAGES - 1) ? '0 : r_page + 1'b1;
  assign w_in_range = 32'(selector_in) < NUM_PAGES;
  assign w_onehot = NUM_PAGES'(1) << (SEL_W'(NUM_PAGES - 1) - r_page);
  // Digits/selector_out follow the page register one cycle behind; freeze holds everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= MANUAL;
      r_page  <= '0;
      r_cnt   <= '0;
      r_oor   <= 1'b0;
      r_l     <= '0;
      r_r     <= '0;
      r_sel   <= '0;
      r_upd   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == FREEZE) begin
        r_upd <= 1'b0;
      end else begin
        r_l   <= w_l[r_page];
        r_r   <= w_r[r_page];
        r_sel <= r_oor ? '0 : w_onehot;
        r_upd <= {w_l[r_page], w_r[r_page]} != {r_l, r_r};
        if (w_next == AUTO) begin
          r_oor  <= 1'b0;
          r_cnt  <= w_adv ? '0 : r_cnt + 1'b1;
          r_page <= w_adv ? w_page_inc : r_page;
        end else begin
          r_cnt  <= '0;
          r_oor  <= !w_in_range;
          r_page <= w_in_range ? selector_in : r_page;
        end
      end
    end
  end
  assign l_digits     = r_l;
  assign r_digits     = r_r;
  assign selector_out = r_sel;
  assign page_index   = r_page;
  assign frozen       = r_state == FREEZE;
  assign update_pulse = r_upd;
endmodule

// File: tb/tb_display_page_scanner.sv
// tb_display_page_scanner: directed table plus corner sequences for display_page_scanner
module tb_display_page_scanner;
  logic clock = 1'b0;
  logic reset, auto_mode, step, freeze;
  logic [2:0] selector_in;
  logic [255:0] page_data;
  logic [15:0] l_digits, r_digits, l6, r6;
  logic [7:0] selector_out;
  logic [5:0] sel6;
  logic [2:0] page_index, idx6;
  logic frozen, update_pulse, frz6, upd6;
  int n_pass = 0, n_total = 0;

  always #5 clock = ~clock;

  display_page_scanner #(.NUM_PAGES(8), .WORD_W(16), .DWELL(4)) dut (
    .clock(clock), .reset(reset), .page_data(page_data), .selector_in(selector_in),
    .auto_mode(auto_mode), .step(step), .freeze(freeze), .l_digits(l_digits),
    .r_digits(r_digits), .selector_out(selector_out), .page_index(page_index),
    .frozen(frozen), .update_pulse(update_pulse));

  display_page_scanner #(.NUM_PAGES(6), .WORD_W(16), .DWELL(4)) dut6 (
    .clock(clock), .reset(reset), .page_data(page_data[191:0]), .selector_in(selector_in),
    .auto_mode(auto_mode), .step(step), .freeze(freeze), .l_digits(l6),
    .r_digits(r6), .selector_out(sel6), .page_index(idx6),
    .frozen(frz6), .update_pulse(upd6));

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] l, r;
    logic [7:0]  so;
  } vec_t;
  vec_t tbl [5];
  logic [15:0] init_l [8];
  logic [15:0] init_r [8];

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic setp(input int k, input logic [15:0] l, input logic [15:0] r);
    page_data[(2*k+1)*16 +: 16] = l;
    page_data[2*k*16 +: 16] = r;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    init_l = '{16'h1000, 16'h1111, 16'h1234, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777};
    init_r = '{16'hF000, 16'hE111, 16'hABCD, 16'hC333, 16'hB444, 16'hA555, 16'h9666, 16'h8777};
    tbl[0] = '{3'd5, 16'h5555, 16'hA555, 8'b0000_0100};
    tbl[1] = '{3'd0, 16'h1000, 16'hF000, 8'b1000_0000};
    tbl[2] = '{3'd7, 16'h7777, 16'h8777, 8'b0000_0001};
    tbl[3] = '{3'd3, 16'h3333, 16'hC333, 8'b0001_0000};
    tbl[4] = '{3'd6, 16'h6666, 16'h9666, 8'b0000_0010};
    reset = 1; selector_in = 0; auto_mode = 0; step = 0; freeze = 0; page_data = '0;
    for (int k = 0; k < 8; k++) setp(k, init_l[k], init_r[k]);
    repeat (3) tick;
    chk("rst_idx", 32'(page_index), 0);
    chk("rst_l", 32'(l_digits), 0);
    chk("rst_r", 32'(r_digits), 0);
    chk("rst_so", 32'(selector_out), 0);
    chk("rst_frozen", 32'(frozen), 0);
    chk("rst_upd", 32'(update_pulse), 0);
    // selector -> digits takes two cycles
    reset = 0; selector_in = 3'd2;
    tick;
    chk("t1_idx", 32'(page_index), 2);
    chk("t1_l_page0", 32'(l_digits), 32'h1000);
    tick;
    chk("t1_l", 32'(l_digits), 32'h1234);
    chk("t1_r", 32'(r_digits), 32'hABCD);
    chk("t1_so", 32'(selector_out), 32'b0010_0000);
    chk("t1_upd", 32'(update_pulse), 1);
    tick;
    chk("t1_upd_off", 32'(update_pulse), 0);
    for (int i = 0; i < 5; i++) begin
      selector_in = tbl[i].sel;
      tick;
      tick;
      chk($sformatf("tbl%0d_l", i), 32'(l_digits), 32'(tbl[i].l));
      chk($sformatf("tbl%0d_r", i), 32'(r_digits), 32'(tbl[i].r));
      chk($sformatf("tbl%0d_so", i), 32'(selector_out), 32'(tbl[i].so));
      chk($sformatf("tbl%0d_idx", i), 32'(page_index), 32'(tbl[i].sel));
    end
    // data -> digits in one cycle
    setp(6, 16'h0F0F, 16'hF0F0);
    tick;
    chk("data_l", 32'(l_digits), 32'h0F0F);
    chk("data_r", 32'(r_digits), 32'hF0F0);
    chk("data_upd", 32'(update_pulse), 1);
    // out-of-range manual selection on the 6-page instance
    selector_in = 3'd4;
    tick;
    tick;
    chk("t2_idx6", 32'(idx6), 4);
    chk("t2_so6", 32'(sel6), 32'b000010);
    selector_in = 3'd7;
    tick;
    chk("t2_idx6_hold", 32'(idx6), 4);
    tick;
    chk("t2_so6_zero", 32'(sel6), 0);
    chk("t2_l6", 32'(l6), 32'h4444);
    // auto scan with wrap
    selector_in = 3'd6;
    tick;
    tick;
    auto_mode = 1;
    repeat (3) tick;
    chk("t3_idx_6", 32'(page_index), 6);
    tick;
    chk("t3_idx_7", 32'(page_index), 7);
    repeat (4) tick;
    chk("t3_idx_0", 32'(page_index), 0);
    tick;
    chk("t3_l0", 32'(l_digits), 32'h1000);
    // step coincident with dwell expiry at page 1
    repeat (3) tick;
    chk("t4_idx_1", 32'(page_index), 1);
    repeat (3) tick;
    step = 1;
    tick;
    step = 0;
    chk("t4_idx_2", 32'(page_index), 2);
    repeat (3) tick;
    chk("t4_hold_2", 32'(page_index), 2);
    tick;
    chk("t4_idx_3", 32'(page_index), 3);
    step = 1;
    tick;
    step = 0;
    chk("t4_step", 32'(page_index), 4);
    // freeze snapshot
    auto_mode = 0; selector_in = 3'd2;
    repeat (3) tick;
    chk("t5_pre_l", 32'(l_digits), 32'h1234);
    chk("t5_pre_upd", 32'(update_pulse), 0);
    freeze = 1; step = 1;
    tick;
    chk("t5_frozen", 32'(frozen), 1);
    chk("t5_l_hold", 32'(l_digits), 32'h1234);
    setp(2, 16'hFFFF, 16'hABCD);
    step = 0;
    tick;
    chk("t5_l_hold2", 32'(l_digits), 32'h1234);
    chk("t5_upd_frz", 32'(update_pulse), 0);
    chk("t5_idx", 32'(page_index), 2);
    freeze = 0;
    tick;
    chk("t5_l_rel", 32'(l_digits), 32'hFFFF);
    chk("t5_upd_rel", 32'(update_pulse), 1);
    chk("t5_unfrozen", 32'(frozen), 0);
    tick;
    chk("t5_upd_once", 32'(update_pulse), 0);
    // reset in the middle of auto scan
    auto_mode = 1; selector_in = 3'd0;
    repeat (12) tick;
    chk("t6_idx_5", 32'(page_index), 5);
    tick;
    reset = 1;
    tick;
    chk("t6_idx", 32'(page_index), 0);
    chk("t6_l", 32'(l_digits), 0);
    chk("t6_r", 32'(r_digits), 0);
    chk("t6_so", 32'(selector_out), 0);
    chk("t6_frozen", 32'(frozen), 0);
    chk("t6_upd", 32'(update_pulse), 0);
    reset = 0; auto_mode = 0; selector_in = 3'd3;
    tick;
    chk("t6_manual", 32'(page_index), 3);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
